// File: rtl/interp_filter.sv
// interp_filter: linear-interpolating upsampler, R = 1..16 outputs per input.
// Ports: clk, reset (sync, active-high), interp_sel, in_valid/in_ready/d in,
//        out_valid/q out (q registered, signed BIT_WIDTH).
module interp_filter #(
    parameter int BIT_WIDTH = 24,
    parameter int RANGE     = BIT_WIDTH - 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         interp_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [RANGE:0] d,
    output logic               out_valid,
    output logic signed [RANGE:0] q
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] STARVE = 2'd2;

    logic signed [RANGE:0]       prev;
    logic signed [RANGE:0]       curr;
    logic [3:0]                  phase;
    logic [2:0]                  k_lat;
    logic [1:0]                  state;

    logic [3:0]                  last_phase;
    logic                        seg_end;
    logic                        accept;
    logic [2:0]                  k_sel;
    logic signed [BIT_WIDTH:0]   diff;
    logic signed [BIT_WIDTH+4:0] prod;
    logic signed [BIT_WIDTH+4:0] scaled;
    logic signed [RANGE:0]       interp;

    assign last_phase = 4'((5'd1 << k_lat) - 5'd1);
    assign seg_end    = (phase == last_phase);
    assign in_ready   = !reset && ((state != RUN) || seg_end);
    assign accept     = in_valid && in_ready;

    assign k_sel = interp_sel[2] ? 3'd4 : {1'b0, interp_sel[1:0]};

    // One extra bit keeps curr-prev exact; the product grows by the 4-bit phase.
    assign diff   = $signed({curr[RANGE], curr}) - $signed({prev[RANGE], prev});
    assign prod   = $signed({{4{diff[BIT_WIDTH]}}, diff})
                  * $signed({{(BIT_WIDTH + 1){1'b0}}, phase});
    assign scaled = prod >>> k_lat;
    // Result lies between prev and curr, so truncation cannot wrap.
    assign interp = prev + $signed(scaled[RANGE:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev      <= '0;
            curr      <= '0;
            phase     <= '0;
            k_lat     <= '0;
            state     <= EMPTY;
            q         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == RUN) begin
                q         <= interp;
                out_valid <= 1'b1;
                phase     <= phase + 4'd1;
                if (seg_end && !accept) begin
                    state <= STARVE;
                    phase <= phase;
                end
            end
            // Load after the RUN update so a phase R-1 accept stays gapless.
            if (accept) begin
                prev  <= curr;
                curr  <= d;
                phase <= '0;
                k_lat <= k_sel;
                state <= RUN;
            end
        end
    end

endmodule

// File: doc/interp_filter.md
# interp_filter

Linear-interpolating upsampler: the expanding counterpart to the running-average low-pass filter in the audio path. It takes signed samples at a low rate through a valid/ready handshake and emits one sample per clock at R = 1, 2, 4, 8 or 16 times the input rate. Each output is a straight-line interpolation between the previous and current input samples. It sits in the playback direction, feeding the DAC-side path where the filter's averaged stream would be restored to full rate.

## Interface
- BIT_WIDTH, 24, sample width (two's complement)
- RANGE, BIT_WIDTH-1, MSB index of sample buses
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- interp_sel  in  3  ratio select: 000→R=1, 001→2, 010→4, 011→8, 1xx→16 (k = log2 R)
- in_valid  in  1  d holds a sample
- in_ready  out  1  block accepts d this cycle (combinational from state)
- d  in  BIT_WIDTH  signed input sample
- out_valid  out  1  q updated this cycle
- q  out  BIT_WIDTH  signed interpolated output (registered)

## Operation
- Registers: prev, curr (BIT_WIDTH signed), phase (4-bit), k_lat (3-bit), state ∈ {EMPTY, RUN, STARVE}.
- Accept = in_valid & in_ready at a rising edge. On accept: prev←curr, curr←d, phase←0, k_lat←k decoded from interp_sel, state←RUN.
- in_ready = !reset & (state≠RUN | phase==R_lat−1), where R_lat = 2^k_lat.
- In RUN, each edge: q ← prev + ((curr−prev)·phase >>> k_lat); out_valid←1; phase←phase+1.
- Arithmetic: diff is BIT_WIDTH+1 bits signed; product is BIT_WIDTH+5 bits signed, with phase zero-extended. `>>>` is arithmetic, so it floors toward −∞. The sum is truncated to BIT_WIDTH bits. The result always lies between prev and curr inclusive, so no saturation is needed.
- At the edge where phase==R_lat−1:
  - With an accept: output for phase R_lat−1 is produced, the accept-load applies, and the block stays in RUN. Output stays gapless.
  - Without an accept: the final output is produced, state←STARVE.
- STARVE / EMPTY: out_valid←0, q holds its last value, phase holds.
- interp_sel is sampled only on accept. A change mid-segment takes effect at the next accept.
- The first segment after reset interpolates from 0 (reset value of curr) to the first sample.
- R=1: in_ready stays high in RUN, and q = prev, i.e. the input delayed by one accept.

## Timing
- Reset values: q=0, out_valid=0, in_ready=0 while reset is high. After reset: prev=curr=0, phase=0, k_lat=0, state=EMPTY, in_ready=1.
- Accept at edge t → outputs for phases 0..R−1 become visible after edges t+1..t+R. Phase 0 output = prev (old curr).
- Sustained throughput: one input per R clocks and one output per clock when in_valid is always high at phase R−1.
- Reset asserted mid-segment: at that edge all registers clear to reset values and the partial segment is discarded. A sample presented during reset is not accepted.
- in_valid high while in_ready is low: no effect, and d need not be held.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 → q=0, out_valid=0, in_ready=0; after release in_ready=1, state EMPTY, no out_valid.
- Ratio 4 (interp_sel=010): accept 0, then 400 on the first ready cycle after the 0-segment → q = 0,0,0,0, then 0,100,200,300 on consecutive clocks, out_valid continuous, in_ready high only on each 4th cycle.
- Negative floor (interp_sel=001): segment prev=0, curr=−3 → q = 0, −2.
- Starvation: R=8, in_valid low at phase 7 → out_valid drops next cycle, q holds the phase-7 value. The accept 3 cycles later → out_valid resumes with phase 0 = old curr.
- Select change and extremes:
  - Switch interp_sel 011→1xx mid-segment → the current segment still has 8 outputs; the next segment has 16.
  - Segment 0x7FFFFF→0x800000 at R=16, phase 15 → q = −7340033 (0x8FFFFF), no wrap.
- Reset mid-segment: R=16, assert reset at phase 5 → q=0, out_valid=0 next cycle. The next accept of 160 yields 0,10,20,…,150.
